riscv_decode_issue: RTL and testbench

// - RV64IM decode/issue stage: accepts raw 32-bit instruction words with their PCs and decodes them into
//   op id, register indices and a 64-bit immediate.
// - Delivers decoded records to the executer through a 2-entry buffered valid/ready stage.
// - Feeds the executer the (opcode, rd, rs1, rs2, immediate, pc) tuple it consumes; keeps decoded/illegal

---
 rtl/riscv_decode_issue.sv | 242 ++++++++++++++++++++++++
 tb/tb_riscv_decode_issue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decode_issue.sv
// RV64IM decode/issue stage: combinational decode of raw instruction words into a small
// FIFO that feeds the executer over valid/ready, with handover statistics counters.
module riscv_decode_issue #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [63:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_op,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [63:0]      out_imm,
    output logic [63:0]      out_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] decoded_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic [63:0] pc;
        logic        illegal;
    } rec_t;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm_i;
    logic [63:0] imm_u;
    logic [63:0] imm_j;
    logic [5:0]  op_id;
    rec_t        dec;

    assign opc   = in_insn[6:0];
    assign f3    = in_insn[14:12];
    assign f7    = in_insn[31:25];
    assign imm_i = {{52{in_insn[31]}}, in_insn[31:20]};
    assign imm_u = {{32{in_insn[31]}}, in_insn[31:12], 12'h000};
    assign imm_j = {{43{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20],
                    in_insn[30:21], 1'b0};

    // Op id selection; 0 means the opcode/funct combination is not recognised.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        op_id = 6'd0;
        case (opc)
            7'h33: begin
                case (f7)
                    7'h00: begin
                        case (f3)
                            3'd0: op_id = 6'd1;
                            3'd1: op_id = 6'd27;
                            3'd2: op_id = 6'd12;
                            3'd3: op_id = 6'd13;
                            3'd4: op_id = 6'd3;
                            3'd5: op_id = 6'd28;
                            3'd6: op_id = 6'd4;
                            default: op_id = 6'd5;
                        endcase
                    end
                    7'h20: begin
                        if (f3 == 3'd0) op_id = 6'd8;
                        else if (f3 == 3'd5) op_id = 6'd29;
                    end
                    7'h01: begin
                        case (f3)
                            3'd0: op_id = 6'd41;
                            3'd1: op_id = 6'd43;
                            3'd2: op_id = 6'd44;
                            3'd3: op_id = 6'd45;
                            3'd4: op_id = 6'd37;
                            3'd5: op_id = 6'd38;
                            3'd6: op_id = 6'd33;
                            default: op_id = 6'd34;
                        endcase
                    end
                    default: op_id = 6'd0;
                endcase
            end
            7'h3B: begin
                case (f7)
                    7'h00: begin
                        if (f3 == 3'd0) op_id = 6'd2;
                        else if (f3 == 3'd1) op_id = 6'd30;
                        else if (f3 == 3'd5) op_id = 6'd31;
                    end
                    7'h20: begin
                        if (f3 == 3'd0) op_id = 6'd9;
                        else if (f3 == 3'd5) op_id = 6'd32;
                    end
                    7'h01: begin
                        case (f3)
                            3'd0: op_id = 6'd42;
                            3'd4: op_id = 6'd39;
                            3'd5: op_id = 6'd40;
                            3'd6: op_id = 6'd35;
                            3'd7: op_id = 6'd36;
                            default: op_id = 6'd0;
                        endcase
                    end
                    default: op_id = 6'd0;
                endcase
            end
            7'h13: begin
                case (f3)
                    3'd0: op_id = 6'd6;
                    3'd1: op_id = (f7[6:1] == 6'h00) ? 6'd21 : 6'd0;
                    3'd2: op_id = 6'd10;
                    3'd3: op_id = 6'd11;
                    3'd4: op_id = 6'd15;
                    3'd5: begin
                        if (f7[6:1] == 6'h00) op_id = 6'd22;
                        else if (f7[6:1] == 6'h10) op_id = 6'd23;
                    end
                    3'd6: op_id = 6'd16;
                    default: op_id = 6'd14;
                endcase
            end
            7'h1B: begin
                if (f3 == 3'd0) op_id = 6'd7;
                else if (f3 == 3'd1 && f7 == 7'h00) op_id = 6'd24;
                else if (f3 == 3'd5 && f7 == 7'h00) op_id = 6'd25;
                else if (f3 == 3'd5 && f7 == 7'h20) op_id = 6'd26;
            end
            7'h37: op_id = 6'd17;
            7'h17: op_id = 6'd18;
            7'h6F: op_id = 6'd19;
            7'h67: op_id = (f3 == 3'd0) ? 6'd20 : 6'd0;
            default: op_id = 6'd0;
        endcase
    end

    // Field extraction by format; fields a format does not use stay zero.
    always_comb begin
        dec    = '0;
        dec.pc = in_pc;
        if (op_id == 6'd0) begin
            dec.illegal = 1'b1;
        end else begin
            dec.op = op_id;
            dec.rd = in_insn[11:7];
            case (opc)
                7'h33, 7'h3B: begin
                    dec.rs1 = in_insn[19:15];
                    dec.rs2 = in_insn[24:20];
                end
                7'h13, 7'h1B: begin
                    dec.rs1 = in_insn[19:15];
                    if (f3 == 3'd1 || f3 == 3'd5)
                        dec.imm = (opc == 7'h13) ? {58'd0, in_insn[25:20]} : {59'd0, in_insn[24:20]};
                    else
                        dec.imm = imm_i;
                end
                7'h67: begin
                    dec.rs1 = in_insn[19:15];
                    dec.imm = imm_i;
                end
                7'h37, 7'h17: dec.imm = imm_u;
                7'h6F:        dec.imm = imm_j;
                default:      dec.imm = '0;
            endcase
        end
    end

    rec_t             mem [DEPTH];
    rec_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_valid = (occ != '0);
    assign push      = reset_n & ~flush & in_valid & in_ready;
    assign pop       = reset_n & ~flush & out_valid & out_ready;
    assign head      = mem[rd_ptr];

    always_comb begin
        case ({push, pop})
            2'b10:   occ_next = occ + OCC_W'(1);
            2'b01:   occ_next = occ - OCC_W'(1);
            default: occ_next = occ;
        endcase
    end

    // NOTE: record storage has no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            in_ready    <= 1'b0;
            decoded_cnt <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr      <= ptr_inc(rd_ptr);
                decoded_cnt <= decoded_cnt + CNT_W'(1);
                if (head.illegal) illegal_cnt <= illegal_cnt + CNT_W'(1);
            end
            occ      <= occ_next;
            in_ready <= (occ_next < OCC_W'(DEPTH));
        end
    end

    assign out_op      = out_valid ? head.op      : '0;
    assign out_rd      = out_valid ? head.rd      : '0;
    assign out_rs1     = out_valid ? head.rs1     : '0;
    assign out_rs2     = out_valid ? head.rs2     : '0;
    assign out_imm     = out_valid ? head.imm     : '0;
    assign out_pc      = out_valid ? head.pc      : '0;
    assign out_illegal = out_valid ? head.illegal : 1'b0;
endmodule

// File: tb/tb_riscv_decode_issue.sv
// Bench for riscv_decode_issue: directed vectors plus random traffic against a
// MATCH/MASK table decoder and a queue model of the buffer.
module tb_riscv_decode_issue;
    localparam int DEPTH = 2;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_insn = '0;
    logic [63:0]      in_pc = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [5:0]       out_op;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [63:0]      out_imm;
    logic [63:0]      out_pc;
    logic             out_illegal;
    logic [CNT_W-1:0] decoded_cnt;
    logic [CNT_W-1:0] illegal_cnt;

    riscv_decode_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc),
        .out_illegal(out_illegal), .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef enum {FR, FI, FS6, FS5, FU, FJ} fmt_e;
    typedef struct {
        int          op;
        logic [31:0] match;
        logic [31:0] mask;
        fmt_e        fmt;
    } ent_t;
    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm, pc;
        logic        ill;
    } rec_t;

    ent_t             tbl[$];
    rec_t             q[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] m_dec = '0;
    logic [CNT_W-1:0] m_ill = '0;

    function automatic void add_ent(input int op, input logic [6:0] opc, input int f3,
                                    input int f7, input fmt_e f);
        ent_t e;
        logic [6:0] f7v;
        logic [2:0] f3v;
        f7v = f7[6:0];
        f3v = f3[2:0];
        e.op    = op;
        e.fmt   = f;
        e.match = {f7v, 10'd0, f3v, 5'd0, opc};
        case (f)
            FR, FS5: e.mask = 32'hFE00707F;
            FI:      e.mask = 32'h0000707F;
            FS6:     e.mask = 32'hFC00707F;
            default: e.mask = 32'h0000007F;
        endcase
        tbl.push_back(e);
    endfunction

    function automatic rec_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
        rec_t r;
        r = '{op: 0, rd: 0, rs1: 0, rs2: 0, imm: 0, pc: pc, ill: 1'b1};
        foreach (tbl[i]) begin
            if ((w & tbl[i].mask) == tbl[i].match) begin
                r.ill = 1'b0;
                r.op  = tbl[i].op[5:0];
                r.rd  = w[11:7];
                case (tbl[i].fmt)
                    FR:  begin r.rs1 = w[19:15]; r.rs2 = w[24:20]; end
                    FI:  begin r.rs1 = w[19:15]; r.imm = 64'($signed(w[31:20])); end
                    FS6: begin r.rs1 = w[19:15]; r.imm = 64'(w[25:20]); end
                    FS5: begin r.rs1 = w[19:15]; r.imm = 64'(w[24:20]); end
                    FU:  r.imm = 64'($signed({w[31:12], 12'h000}));
                    default: r.imm = 64'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
                endcase
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        int k;
        if ($urandom_range(0, 3) == 0) return $urandom;
        k = $urandom_range(0, tbl.size() - 1);
        return tbl[k].match | ($urandom & ~tbl[k].mask);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("in_ready", in_ready, q.size() < DEPTH);
        check("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("out_op", out_op, q[0].op);
            check("out_rd", out_rd, q[0].rd);
            check("out_rs1", out_rs1, q[0].rs1);
            check("out_rs2", out_rs2, q[0].rs2);
            check("out_imm", out_imm, q[0].imm);
            check("out_pc", out_pc, q[0].pc);
            check("out_illegal", out_illegal, q[0].ill);
        end
        check("decoded_cnt", decoded_cnt, m_dec);
        check("illegal_cnt", illegal_cnt, m_ill);
    endtask

    // One clock: drive inputs, compare against the model, then advance the model.
    task automatic cycle(input logic v, input logic [31:0] w, input logic [63:0] pc,
                         input logic rdy, input logic fl);
        logic acc, hand;
        in_valid = v; in_insn = w; in_pc = pc; out_ready = rdy; flush = fl;
        check_outputs();
        acc  = v && (q.size() < DEPTH) && !fl;
        hand = (q.size() > 0) && rdy && !fl;
        @(posedge clk); #1;
        if (fl) begin
            q.delete();
        end else begin
            if (hand) begin
                m_dec++;
                if (q[0].ill) m_ill++;
                void'(q.pop_front());
            end
            if (acc) q.push_back(ref_decode(w, pc));
        end
    endtask

    task automatic expect_rec(input string tag, input logic [5:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [63:0] imm, input logic ill);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".op"}, out_op, op);
        check({tag, ".rd"}, out_rd, rd);
        check({tag, ".rs1"}, out_rs1, rs1);
        check({tag, ".rs2"}, out_rs2, rs2);
        check({tag, ".imm"}, out_imm, imm);
        check({tag, ".illegal"}, out_illegal, ill);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; in_valid = 1'b1; in_insn = 32'h00500093; in_pc = 64'h1000;
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        check("rst.in_ready", in_ready, 1'b0);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.fields", {out_op, out_rd, out_rs1, out_rs2, out_illegal}, '0);
        check("rst.imm", out_imm, '0);
        check("rst.pc", out_pc, '0);
        check("rst.decoded_cnt", decoded_cnt, '0);
        check("rst.illegal_cnt", illegal_cnt, '0);
        reset_n = 1'b1; in_valid = 1'b0; flush = 1'b0;
        q.delete(); m_dec = '0; m_ill = '0;
        @(posedge clk); #1;
        check("rst.in_ready_after", in_ready, 1'b1);
    endtask

    task automatic directed(input string tag, input logic [31:0] w, input logic [5:0] op,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [63:0] imm, input logic ill);
        cycle(1'b1, w, 64'h8000_0000, 1'b0, 1'b0);
        in_valid = 1'b0;
        expect_rec(tag, op, rd, rs1, rs2, imm, ill);
        check({tag, ".pc"}, out_pc, 64'h8000_0000);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [CNT_W-1:0] sd, si;
        add_ent(1, 7'h33, 0, 'h00, FR);   add_ent(2, 7'h3B, 0, 'h00, FR);
        add_ent(3, 7'h33, 4, 'h00, FR);   add_ent(4, 7'h33, 6, 'h00, FR);
        add_ent(5, 7'h33, 7, 'h00, FR);   add_ent(6, 7'h13, 0, 0, FI);
        add_ent(7, 7'h1B, 0, 0, FI);      add_ent(8, 7'h33, 0, 'h20, FR);
        add_ent(9, 7'h3B, 0, 'h20, FR);   add_ent(10, 7'h13, 2, 0, FI);
        add_ent(11, 7'h13, 3, 0, FI);     add_ent(12, 7'h33, 2, 'h00, FR);
        add_ent(13, 7'h33, 3, 'h00, FR);  add_ent(14, 7'h13, 7, 0, FI);
        add_ent(15, 7'h13, 4, 0, FI);     add_ent(16, 7'h13, 6, 0, FI);
        add_ent(17, 7'h37, 0, 0, FU);     add_ent(18, 7'h17, 0, 0, FU);
        add_ent(19, 7'h6F, 0, 0, FJ);     add_ent(20, 7'h67, 0, 0, FI);
        add_ent(21, 7'h13, 1, 'h00, FS6); add_ent(22, 7'h13, 5, 'h00, FS6);
        add_ent(23, 7'h13, 5, 'h20, FS6); add_ent(24, 7'h1B, 1, 'h00, FS5);
        add_ent(25, 7'h1B, 5, 'h00, FS5); add_ent(26, 7'h1B, 5, 'h20, FS5);
        add_ent(27, 7'h33, 1, 'h00, FR);  add_ent(28, 7'h33, 5, 'h00, FR);
        add_ent(29, 7'h33, 5, 'h20, FR);  add_ent(30, 7'h3B, 1, 'h00, FR);
        add_ent(31, 7'h3B, 5, 'h00, FR);  add_ent(32, 7'h3B, 5, 'h20, FR);
        add_ent(33, 7'h33, 6, 'h01, FR);  add_ent(34, 7'h33, 7, 'h01, FR);
        add_ent(35, 7'h3B, 6, 'h01, FR);  add_ent(36, 7'h3B, 7, 'h01, FR);
        add_ent(37, 7'h33, 4, 'h01, FR);  add_ent(38, 7'h33, 5, 'h01, FR);
        add_ent(39, 7'h3B, 4, 'h01, FR);  add_ent(40, 7'h3B, 5, 'h01, FR);
        add_ent(41, 7'h33, 0, 'h01, FR);  add_ent(42, 7'h3B, 0, 'h01, FR);
        add_ent(43, 7'h33, 1, 'h01, FR);  add_ent(44, 7'h33, 2, 'h01, FR);
        add_ent(45, 7'h33, 3, 'h01, FR);

        do_reset();

        directed("addi5",  32'h00500093, 6'd6,  5'd1, 5'd0, 5'd0, 64'd5, 1'b0);
        directed("addim1", 32'hFFF00113, 6'd6,  5'd2, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        directed("lui",    32'h123452B7, 6'd17, 5'd5, 5'd0, 5'd0, 64'h0000_0000_1234_5000, 1'b0);
        directed("add",    32'h002081B3, 6'd1,  5'd3, 5'd1, 5'd2, 64'd0, 1'b0);
        directed("mul",    32'h022081B3, 6'd41, 5'd3, 5'd1, 5'd2, 64'd0, 1'b0);
        directed("srai3",  32'h4030D093, 6'd23, 5'd1, 5'd1, 5'd0, 64'd3, 1'b0);
        directed("srai32", 32'h4200D093, 6'd23, 5'd1, 5'd1, 5'd0, 64'd32, 1'b0);
        directed("zero",   32'h00000000, 6'd0,  5'd0, 5'd0, 5'd0, 64'd0, 1'b1);
        directed("slliw25", 32'h0210109B, 6'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b1);
        directed("jalr_f3", 32'h00009067, 6'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b1);
        check("directed.illegal_cnt", illegal_cnt, 32'd3);

        // Backpressure: three words offered while the executer stalls.
        do_reset();
        cycle(1'b1, 32'h00500093, 64'h100, 1'b0, 1'b0);
        cycle(1'b1, 32'h002081B3, 64'h104, 1'b0, 1'b0);
        check("bp.in_ready_third", in_ready, 1'b0);
        cycle(1'b1, 32'h123452B7, 64'h108, 1'b0, 1'b0);
        cycle(1'b1, 32'h123452B7, 64'h108, 1'b0, 1'b0);
        check("bp.hold_pc", out_pc, 64'h100);
        check("bp.hold_op", out_op, 6'd6);
        cycle(1'b1, 32'h123452B7, 64'h108, 1'b1, 1'b0);
        check("bp.second_pc", out_pc, 64'h104);
        cycle(1'b1, 32'h123452B7, 64'h108, 1'b1, 1'b0);
        check("bp.third_pc", out_pc, 64'h108);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        check("bp.decoded_cnt", decoded_cnt, 32'd3);

        // Flush with two entries buffered and a word on the input.
        cycle(1'b1, 32'h00000000, 64'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'h022081B3, 64'h204, 1'b0, 1'b0);
        sd = decoded_cnt; si = illegal_cnt;
        cycle(1'b1, 32'h4030D093, 64'h208, 1'b1, 1'b1);
        in_valid = 1'b0; flush = 1'b0;
        check("flush.out_valid", out_valid, 1'b0);
        check("flush.in_ready", in_ready, 1'b1);
        check("flush.decoded_cnt", decoded_cnt, sd);
        check("flush.illegal_cnt", illegal_cnt, si);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_word(), {$urandom, $urandom},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
        end

        // Reset mid-stream with traffic in flight.
        cycle(1'b1, 32'h002081B3, 64'h300, 1'b0, 1'b0);
        cycle(1'b1, 32'h00000000, 64'h304, 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 32'h00500093, 64'h400, 1'b0, 1'b0);
        expect_rec("post_rst", 6'd6, 5'd1, 5'd0, 5'd0, 64'd5, 1'b0);
        check("post_rst.pc", out_pc, 64'h400);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        check("post_rst.decoded_cnt", decoded_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
